fetch_ctrl: RTL and testbench
=============================

# fetch_ctrl

Instruction-fetch controller for the 24-bit pipelined core. It owns the program counter and the fetch/decode instruction register (IR), and drives the program-memory address. It is the consumer of the stall-control outputs: it holds, bubbles, redirects and halts the front end in response to `stall` and `stall_pm`. It also self-decodes jump and halt opcodes from fetched words.

## Interface
- `PC_WIDTH`, 8, program-counter and program-memory address width
- `RESET_PC`, 0, PC value loaded on reset
- `clk`  input  1  system clock; all state updates on the rising edge
- `reset`  input  1  asynchronous, active-high; clears all state immediately
- `stall`  input  1  combinational stall request from the stall controller
- `stall_pm`  input  1  registered stall (`stall` delayed one cycle), program-memory side
- `pm_data`  input  24  program-memory read data; combinational read of `pm_addr` in the same cycle
- `pm_addr`  output  PC_WIDTH  program-memory address; equals the PC register
- `pm_en`  output  1  program-memory read enable
- `ir`  output  24  instruction presented to decode
- `ir_valid`  output  1  `ir` holds a real instruction (0 = bubble)
- `ir_pc`  output  PC_WIDTH  address `ir` was fetched from
- `halted`  output  1  fetch is frozen by HLT
- `stall_cnt`  output  16  saturating count of stall/bubble cycles

## Operation
- Opcode is `word[23:19]`. HLT = 5'b10001. JUMP = 5'b111xx. The jump target is `ir[PC_WIDTH-1:0]`, an absolute address. NOP = 24'h000000.
- States: RUN, REDIR, HALT. Reset enters RUN.
- `pm_en` = (state==RUN) & ~stall & ~stall_pm. It is a combinational output.
- Edge-update priority, highest first:
  1. **HALT:** nothing changes. `halted`=1. Only `reset` exits HALT.
  2. **stall=1 (RUN or REDIR):** PC, `ir`, `ir_valid`, `ir_pc` and state all hold.
  3. **stall_pm=1, stall=0:**
     - `ir`<=NOP, `ir_valid`<=0.
     - PC holds; state is unchanged.
  4. **REDIR:**
     - `ir`<=NOP, `ir_valid`<=0.
     - PC holds (it already contains the target).
     - Next state RUN.
  5. **RUN, `ir_valid`=1 and `ir` is JUMP:**
     - PC<=target.
     - `ir`<=NOP, `ir_valid`<=0.
     - Next state REDIR.
  6. **RUN, normal fetch:**
     - `ir`<=`pm_data`, `ir_pc`<=PC, `ir_valid`<=1.
     - If `pm_data` is HLT: PC holds and next state is HALT.
     - Otherwise PC<=PC+1, modulo 2^PC_WIDTH (all-ones wraps to 0).
- `stall_cnt` increments on any edge where `stall|stall_pm` is 1 and state != HALT. It saturates at 16'hFFFF.
- Reset values:
  - PC=`pm_addr`=RESET_PC.
  - `ir`=0, `ir_valid`=0, `ir_pc`=0.
  - `halted`=0, `stall_cnt`=0, state=RUN.

## Timing
- Fetch latency is 1 cycle: the word at `pm_addr` in cycle n appears on `ir` in cycle n+1.
- Sustained throughput is 1 instruction/cycle with no stalls.
- LD sequence: `stall` is high for 1 cycle, then `stall_pm` is high for 1 cycle. Result: `ir` holds for 1 cycle, then 1 bubble. Fetch resumes on the third edge.
- Jump cost:
  - The stall controller raises `stall` for 2 cycles while the JUMP sits in `ir`; `ir` holds throughout.
  - Edge after `stall` drops (and `stall_pm`, if high): redirect.
  - Then 1 REDIR bubble.
  - The target word appears on `ir` on the following edge.
- HLT: the HLT word appears on `ir` with `ir_valid`=1 one cycle after fetch. `halted` rises on that same edge.
- Reset assertion mid-operation clears all state asynchronously, with no clock needed. The first fetch is from RESET_PC on the first edge after deassertion.
- A jump target equal to the JUMP's own address is legal and loops.
- `stall` during REDIR delays the REDIR→RUN exit.

## Test plan
- **Reset/straight-line:** RESET_PC=0, ROM words 0x010000+k at address k, no stalls.
  - `ir` = 0x010000, 0x010001, 0x010002 on consecutive cycles.
  - `ir_pc` = 0, 1, 2; `pm_en`=1 throughout.
- **LD stall:** drive `stall`=1 for 1 cycle, then `stall_pm`=1 for 1 cycle, while `ir`=LD from addr 3.
  - `ir` holds the LD for 1 extra cycle, then NOP with `ir_valid`=0.
  - Next valid `ir_pc`=4; `stall_cnt`=2.
- **Jump:** addr 5 = 0xE00020 (JUMP to 0x20); `stall` high for 2 cycles.
  - PC=0x20 after the redirect edge, then 1 REDIR bubble.
  - `ir_pc`=0x20 valid 1 cycle later; no word from address 6 is ever valid.
- **Halt then reset:** addr 2 = 0x880000 (HLT).
  - `halted`=1 and PC=2 frozen for 20 cycles; `stall_cnt` is unchanged even with `stall`=1.
  - Assert `reset` between edges: outputs clear immediately. Fetch resumes at addr 0.
- **Wrap:** PC_WIDTH=8, start fetch at 0xFE. Required sequence `ir_pc` = 0xFE, 0xFF, 0x00.
- **Saturation:** hold `stall`=1 for 70000 cycles. `stall_cnt`=0xFFFF with no wrap; PC unchanged.

Source files
------------

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC and the fetch/decode IR, and applies
// hold/bubble/redirect/halt in response to the stall controller.
module fetch_ctrl #(
    parameter int unsigned PC_WIDTH = 8,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                stall_pm,
    input  logic [23:0]         pm_data,
    output logic [PC_WIDTH-1:0] pm_addr,
    output logic                pm_en,
    output logic [23:0]         ir,
    output logic                ir_valid,
    output logic [PC_WIDTH-1:0] ir_pc,
    output logic                halted,
    output logic [15:0]         stall_cnt
);

    typedef enum logic [1:0] {RUN, REDIR, HALT} state_t;

    localparam logic [4:0]  OP_HLT = 5'b10001;
    localparam logic [23:0] NOP    = '0;

    state_t              state;
    logic [PC_WIDTH-1:0] pc;

    assign pm_addr = pc;
    assign pm_en   = (state == RUN) && !stall && !stall_pm;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= RUN;
            pc        <= PC_WIDTH'(RESET_PC);
            ir        <= '0;
            ir_valid  <= 1'b0;
            ir_pc     <= '0;
            halted    <= 1'b0;
            stall_cnt <= '0;
        end else begin
            if (state != HALT && (stall || stall_pm) && stall_cnt != '1)
                stall_cnt <= stall_cnt + 16'd1;

            // HALT freezes everything; stall holds the whole front end.
            if (state != HALT && !stall) begin
                if (stall_pm) begin
                    ir       <= NOP;
                    ir_valid <= 1'b0;
                end else if (state == REDIR) begin
                    ir       <= NOP;
                    ir_valid <= 1'b0;
                    state    <= RUN;
                end else if (ir_valid && ir[23:21] == 3'b111) begin
                    pc       <= ir[PC_WIDTH-1:0];
                    ir       <= NOP;
                    ir_valid <= 1'b0;
                    state    <= REDIR;
                end else begin
                    ir       <= pm_data;
                    ir_pc    <= pc;
                    ir_valid <= 1'b1;
                    if (pm_data[23:19] == OP_HLT) begin
                        state  <= HALT;
                        halted <= 1'b1;
                    end else begin
                        pc <= pc + PC_WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: straight-line fetch, LD stall, jump, halt/reset,
// PC wrap with stall during redirect, and stall counter saturation.
module tb_fetch_ctrl;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        stall_pm;
    logic [23:0] pm_data;
    logic [7:0]  pm_addr;
    logic        pm_en;
    logic [23:0] ir;
    logic        ir_valid;
    logic [7:0]  ir_pc;
    logic        halted;
    logic [15:0] stall_cnt;

    logic [23:0] rom [0:255];
    int unsigned n_tests = 0;
    int unsigned n_fail  = 0;
    logic        saw_addr6 = 1'b0;

    fetch_ctrl #(.PC_WIDTH(8), .RESET_PC(0)) dut (
        .clk      (clk),
        .reset    (reset),
        .stall    (stall),
        .stall_pm (stall_pm),
        .pm_data  (pm_data),
        .pm_addr  (pm_addr),
        .pm_en    (pm_en),
        .ir       (ir),
        .ir_valid (ir_valid),
        .ir_pc    (ir_pc),
        .halted   (halted),
        .stall_cnt(stall_cnt)
    );

    assign pm_data = rom[pm_addr];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk)
        if (!reset && ir_valid && ir_pc == 8'd6) saw_addr6 <= 1'b1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        stall    = 1'b0;
        stall_pm = 1'b0;
        for (int i = 0; i < 256; i++) rom[i] = 24'h010000 | 24'(i);
        rom[5]    = 24'hE00020;
        rom[8'h20] = 24'h020020;

        #12;
        check("rst_pm_addr",   pm_addr,   0);
        check("rst_ir",        ir,        0);
        check("rst_ir_valid",  ir_valid,  0);
        check("rst_ir_pc",     ir_pc,     0);
        check("rst_halted",    halted,    0);
        check("rst_stall_cnt", stall_cnt, 0);
        @(posedge clk); #1;
        reset = 1'b0;

        // straight-line fetch
        tick();
        check("sl0_ir", ir, 24'h010000); check("sl0_pc", ir_pc, 0); check("sl0_en", pm_en, 1);
        tick();
        check("sl1_ir", ir, 24'h010001); check("sl1_pc", ir_pc, 1); check("sl1_en", pm_en, 1);
        tick();
        check("sl2_ir", ir, 24'h010002); check("sl2_pc", ir_pc, 2); check("sl2_valid", ir_valid, 1);
        tick();
        check("ld_ir", ir, 24'h010003); check("ld_pc", ir_pc, 3);

        // LD: stall one cycle, then stall_pm one cycle
        stall = 1'b1;
        #1 check("ld_en_stall", pm_en, 0);
        tick();
        check("ld_hold_ir", ir, 24'h010003); check("ld_hold_pc", ir_pc, 3);
        check("ld_hold_valid", ir_valid, 1);
        stall = 1'b0; stall_pm = 1'b1;
        tick();
        check("ld_bub_ir", ir, 0); check("ld_bub_valid", ir_valid, 0);
        check("ld_bub_addr", pm_addr, 4);
        stall_pm = 1'b0;
        tick();
        check("ld_next_pc", ir_pc, 4); check("ld_next_valid", ir_valid, 1);
        check("ld_stall_cnt", stall_cnt, 2);

        // jump at address 5 to 0x20, stall controller holds for 2 cycles
        tick();
        check("j_ir", ir, 24'hE00020); check("j_pc", ir_pc, 5);
        stall = 1'b1;
        tick();
        tick();
        check("j_hold_ir", ir, 24'hE00020); check("j_hold_addr", pm_addr, 6);
        check("j_stall_cnt", stall_cnt, 4);
        stall = 1'b0;
        tick();
        check("j_redir_addr", pm_addr, 8'h20); check("j_redir_valid", ir_valid, 0);
        check("j_redir_en", pm_en, 0);
        tick();
        check("j_bub_valid", ir_valid, 0); check("j_bub_addr", pm_addr, 8'h20);
        check("j_bub_en", pm_en, 1);
        tick();
        check("j_tgt_pc", ir_pc, 8'h20); check("j_tgt_ir", ir, 24'h020020);
        check("j_tgt_valid", ir_valid, 1);

        // halt at address 2, then reset between edges
        rom[2] = 24'h880000;
        reset = 1'b1;
        #1;
        check("ar_addr", pm_addr, 0); check("ar_ir", ir, 0);
        check("ar_valid", ir_valid, 0); check("ar_stall_cnt", stall_cnt, 0);
        #1 reset = 1'b0;
        tick();
        check("h0_pc", ir_pc, 0);
        tick();
        tick();
        check("h_ir", ir, 24'h880000); check("h_valid", ir_valid, 1);
        check("h_ir_pc", ir_pc, 2); check("h_halted", halted, 1);
        check("h_addr", pm_addr, 2);
        stall = 1'b1;
        repeat (20) tick();
        check("h_frz_addr", pm_addr, 2); check("h_frz_halted", halted, 1);
        check("h_frz_cnt", stall_cnt, 0); check("h_frz_ir", ir, 24'h880000);
        check("h_frz_en", pm_en, 0);
        stall = 1'b0;
        tick();
        check("h_stay", halted, 1); check("h_stay_addr", pm_addr, 2);
        reset = 1'b1;
        #1;
        check("h_rst_halted", halted, 0); check("h_rst_addr", pm_addr, 0);
        #1 reset = 1'b0;
        rom[2] = 24'h010002;
        tick();
        check("h_resume_pc", ir_pc, 0); check("h_resume_ir", ir, 24'h010000);

        // wrap: jump from 0 to 0xFE, stall one cycle while redirecting
        rom[0] = 24'hE000FE;
        reset = 1'b1;
        #1 reset = 1'b0;
        tick();
        check("w_jmp_ir", ir, 24'hE000FE);
        tick();
        check("w_redir_addr", pm_addr, 8'hFE); check("w_redir_valid", ir_valid, 0);
        stall = 1'b1;
        tick();
        check("w_rs_valid", ir_valid, 0); check("w_rs_addr", pm_addr, 8'hFE);
        check("w_rs_en", pm_en, 0); check("w_rs_cnt", stall_cnt, 1);
        stall = 1'b0;
        tick();
        check("w_bub_valid", ir_valid, 0); check("w_bub_en", pm_en, 1);
        tick();
        check("w_fe", ir_pc, 8'hFE); check("w_fe_valid", ir_valid, 1);
        tick();
        check("w_ff", ir_pc, 8'hFF); check("w_ff_ir", ir, 24'h0100FF);
        tick();
        check("w_00", ir_pc, 8'h00); check("w_00_addr", pm_addr, 8'h01);

        // saturation
        stall = 1'b1;
        repeat (70000) tick();
        check("sat_cnt", stall_cnt, 16'hFFFF); check("sat_addr", pm_addr, 8'h01);
        check("sat_ir_pc", ir_pc, 8'h00);
        stall = 1'b0;

        check("no_addr6_valid", saw_addr6, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
